// File: rtl/a2_serial_encoder_pkg.sv
// Shared state encoding and saturation constants for the bit-serial
// sign/magnitude to two's-complement encoder.
package a2_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } a2_state_e;

  localparam int A2_DW_DEFAULT = 8;

  // Largest positive word for width dw: 2^(dw-1)-1.
  function automatic logic [63:0] a2_sat_pos(input int dw);
    a2_sat_pos = (64'd1 << (dw - 1)) - 64'd1;
  endfunction

  // Most-negative word for width dw: 2^(dw-1).
  function automatic logic [63:0] a2_sat_neg(input int dw);
    a2_sat_neg = 64'd1 << (dw - 1);
  endfunction

  localparam logic [A2_DW_DEFAULT-1:0] A2_SAT_POS_DEFAULT = A2_DW_DEFAULT'(a2_sat_pos(A2_DW_DEFAULT));
  localparam logic [A2_DW_DEFAULT-1:0] A2_SAT_NEG_DEFAULT = A2_DW_DEFAULT'(a2_sat_neg(A2_DW_DEFAULT));

endpackage

// File: rtl/a2_serial_encoder_negate_cell.sv
// One bit of serial negation: bits up to and including the first 1 are
// copied, every later bit is inverted.
module a2_negate_cell (
  input  logic m_bit,
  input  logic neg,
  input  logic seen_in,
  output logic out_bit,
  output logic seen_out
);

  // Copy/invert decision and running first-one flag
  always_comb begin
    seen_out = seen_in | m_bit;
    if (neg && seen_in) begin
      out_bit = ~m_bit;
    end else begin
      out_bit = m_bit;
    end
  end

endmodule

// File: rtl/a2_serial_encoder.sv
// Bit-serial, LSB-first sign/magnitude to two's-complement encoder with a
// start/busy/done handshake and saturation on unrepresentable magnitudes.
module a2_serial_encoder
  import a2_pkg::*;
#(
  parameter int DW = A2_DW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          sign,
  input  logic [DW-1:0] magnitude,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] result,
  output logic          overflow
);

  localparam int            CW      = $clog2(DW);
  localparam logic [CW-1:0] LAST    = CW'(DW - 1);
  localparam logic [DW-1:0] SAT_POS = DW'(a2_sat_pos(DW));
  localparam logic [DW-1:0] SAT_NEG = DW'(a2_sat_neg(DW));

  a2_state_e     r_state;
  a2_state_e     w_next;
  logic [DW-1:0] r_mag;
  logic [DW-1:0] r_shift;
  logic [DW-1:0] r_result;
  logic [CW-1:0] r_cnt;
  logic          r_sign;
  logic          r_ovf;
  logic          r_ovf_out;
  logic          r_seen;
  logic          r_busy;
  logic          r_done;

  logic          w_ovf;
  logic          w_out_bit;
  logic          w_seen_next;
  logic [DW-1:0] w_shift_next;
  logic [DW-1:0] w_sat;

  a2_negate_cell u_cell (
    .m_bit    (r_mag[r_cnt]),
    .neg      (r_sign & ~r_ovf),
    .seen_in  (r_seen),
    .out_bit  (w_out_bit),
    .seen_out (w_seen_next)
  );

  // Overflow test on the live operand and the matching saturation word
  always_comb begin
    if (sign) begin
      w_ovf = magnitude[DW-1] & (|magnitude[DW-2:0]);
      w_sat = SAT_NEG;
    end else begin
      w_ovf = magnitude[DW-1];
      w_sat = SAT_POS;
    end
  end

  // Saturated operands keep their preloaded word; others shift in from the MSB
  always_comb begin
    if (r_ovf) begin
      w_shift_next = r_shift;
    end else begin
      w_shift_next = {w_out_bit, r_shift[DW-1:1]};
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next = SHIFT;
        end else begin
          w_next = IDLE;
        end
      end
      SHIFT: begin
        if (r_cnt == LAST) begin
          w_next = DONE;
        end else begin
          w_next = SHIFT;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Handshake outputs, operand capture, serial shift and result update
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_mag     <= {DW{1'b0}};
      r_shift   <= {DW{1'b0}};
      r_result  <= {DW{1'b0}};
      r_cnt     <= {CW{1'b0}};
      r_sign    <= 1'b0;
      r_ovf     <= 1'b0;
      r_ovf_out <= 1'b0;
      r_seen    <= 1'b0;
    end else begin
      r_busy <= (w_next != IDLE);
      r_done <= (r_state == DONE);
      case (r_state)
        IDLE: begin
          if (start) begin
            r_sign  <= sign;
            r_mag   <= magnitude;
            r_ovf   <= w_ovf;
            r_cnt   <= {CW{1'b0}};
            r_seen  <= 1'b0;
            r_shift <= w_ovf ? w_sat : {DW{1'b0}};
          end
        end
        SHIFT: begin
          r_cnt   <= r_cnt + CW'(1);
          r_seen  <= w_seen_next;
          r_shift <= w_shift_next;
          // Consumers only ever see the completed word
          if (r_cnt == LAST) begin
            r_result  <= w_shift_next;
            r_ovf_out <= r_ovf;
          end
        end
        DONE: begin
          r_cnt <= {CW{1'b0}};
        end
        default: begin
          r_cnt <= {CW{1'b0}};
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign result   = r_result;
  assign overflow = r_ovf_out;

endmodule

// File: tb/tb_a2_serial_encoder.sv
// Directed bench for a2_serial_encoder: arithmetic reference model feeding a
// scoreboard queue that is drained on every done pulse.
module tb_a2_serial_encoder;

  localparam int DW = 8;

  typedef struct packed {
    logic [DW-1:0] res;
    logic          ovf;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          sign;
  logic [DW-1:0] magnitude;
  logic          busy;
  logic          done;
  logic [DW-1:0] result;
  logic          overflow;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  a2_serial_encoder #(.DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sign      (sign),
    .magnitude (magnitude),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .overflow  (overflow)
  );

  function automatic exp_t model(input logic s, input logic [DW-1:0] m);
    exp_t e;
    int   lim;
    lim = 1 << (DW - 1);
    if (!s) begin
      if (int'(m) > lim - 1) begin e.res = DW'(lim - 1); e.ovf = 1'b1; end
      else                   begin e.res = m;            e.ovf = 1'b0; end
    end else begin
      if (int'(m) > lim) begin e.res = DW'(lim);                    e.ovf = 1'b1; end
      else               begin e.res = DW'((1 << DW) - int'(m));    e.ovf = 1'b0; end
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One conversion; inj_at >= 0 pulses a second start (0x11) in that SHIFT cycle.
  task automatic run_conv(input logic s, input logic [DW-1:0] m, input int inj_at, input string tag);
    exp_t e;
    int   busy_cnt = 0;
    int   done_cnt = 0;
    int   done_at  = -1;
    @(negedge clk);
    start = 1'b1; sign = s; magnitude = m;
    sb_q.push_back(model(s, m));
    @(negedge clk);
    start = 1'b0;
    for (int j = 0; j < DW + 4; j++) begin
      if (j == inj_at) begin start = 1'b1; magnitude = 8'h11; end
      else             begin start = 1'b0; end
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_at = j;
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          chk({tag, "_result"},   32'(result),   32'(e.res));
          chk({tag, "_overflow"}, 32'(overflow), 32'(e.ovf));
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk({tag, "_latency"},  32'(done_at),  32'(DW + 1));
    chk({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    chk({tag, "_busy_cnt"}, 32'(busy_cnt), 32'(DW + 1));
  endtask

  initial begin
    int done_cnt;
    rst = 1'b1; start = 1'b0; sign = 1'b0; magnitude = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);

    // Reset must win over a simultaneous start
    start = 1'b1; sign = 1'b1; magnitude = 8'h05;
    @(negedge clk);
    chk("rst_over_start_busy", 32'(busy), 32'd0);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("rst_over_start_idle", 32'(busy), 32'd0);

    run_conv(1'b1, 8'h05, -1, "neg05");
    run_conv(1'b0, 8'h7F, -1, "pos7f");
    run_conv(1'b1, 8'h80, -1, "neg80");
    run_conv(1'b0, 8'h80, -1, "pos80_sat");
    run_conv(1'b1, 8'hC3, -1, "negc3_sat");
    run_conv(1'b1, 8'h00, -1, "neg_zero");
    run_conv(1'b1, 8'h40, -1, "neg40");
    run_conv(1'b0, 8'h2A, -1, "pos2a");
    run_conv(1'b1, 8'h03, 3, "neg03_ignore");

    // Abort mid-conversion with reset
    @(negedge clk);
    start = 1'b1; sign = 1'b1; magnitude = 8'h07;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_overflow", 32'(overflow), 32'd0);
    done_cnt = 0;
    for (int j = 0; j < DW + 4; j++) begin
      if (done) done_cnt++;
      @(negedge clk);
    end
    chk("abort_no_done", 32'(done_cnt), 32'd0);

    run_conv(1'b1, 8'h01, -1, "neg01_after_abort");

    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/a2_serial_encoder.md
Name: a2_serial_encoder

Overview:
Inverse of the two's-complement magnitude decoder. Takes a sign flag plus unsigned magnitude and produces the DW-bit two's-complement word. The conversion is bit-serial, LSB-first, one bit per clock, using the copy-until-first-one-then-invert rule, so no DW-bit adder is needed. A start/busy/done handshake lets a controller or display path feed operands and read back encoded words.

Parameters:
DW, 8, data width of the magnitude input and the two's-complement result (DW >= 2)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
start  input  1  request conversion; sampled only in IDLE
sign  input  1  1 = negative operand; sampled with start
magnitude  input  DW  unsigned magnitude; sampled with start
busy  output  1  high while a conversion is in progress (SHIFT or DONE)
done  output  1  one-cycle pulse: result and overflow valid
result  output  DW  two's-complement encoding; held until next accepted start
overflow  output  1  magnitude not representable; valid with done, held with result

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high on rst.
- Reset (rst=1 at an edge): state=IDLE, busy=0, done=0, result=0, overflow=0, bit counter=0, seen_one=0. Reset overrides start in the same cycle.
- Reset mid-conversion aborts the conversion. No done pulse is produced and the partial result is discarded (result=0).
- FSM states, held in a package enum:
  - IDLE: busy=0. If start=1, latch sign and magnitude, compute overflow, clear counter and seen_one, go to SHIFT.
  - SHIFT: busy=1. Process one bit per cycle at index i=counter. Shift the output bit into the result shift register from the MSB side, so after DW bits bit 0 sits at result[0]. Increment counter. After bit DW-1, go to DONE.
  - DONE: busy=1, done=1 for exactly one cycle. Go to IDLE.
- Per-bit rule, negative operand and no overflow:
  - out_i = seen_one ? ~m[i] : m[i]
  - seen_one <= seen_one | m[i]
- Positive operand: out_i = m[i].
- Overflow:
  - positive: magnitude > 2^(DW-1)-1
  - negative: magnitude > 2^(DW-1)
  - On overflow the result saturates: 2^(DW-1)-1 for positive, 2^(DW-1) for negative. The saturation value is loaded at start and does not go through the serial path. overflow=1 is held until the next accepted start.
- Boundary values:
  - Negative zero (sign=1, magnitude=0) gives result 0, overflow 0.
  - sign=1, magnitude=2^(DW-1) gives the most-negative word, overflow 0.
- Latency: start sampled at edge k. SHIFT occupies edges k+1..k+DW. done=1 is visible in the cycle after edge k+DW+1. The next start can be accepted at edge k+DW+2, giving a throughput of one conversion per DW+2 cycles.
- start while busy=1 is ignored; no queueing takes place.
- The result register must not show partial values to consumers. Update the output register only on the transition to DONE; the shift register is internal.
- done and busy are registered outputs, with no combinational path from inputs.

Decomposition:
- Shared package a2_pkg: state typedef enum {IDLE, SHIFT, DONE}; localparams for the saturation constants as functions of DW.
- One natural sub-module, a2_negate_cell: a combinational single-bit copy/invert cell with seen_one update. Inputs m_bit, neg, seen_in; outputs out_bit, seen_out. The top level holds the FSM, counter, and shift/output registers.

Test Plan:
(DW=8 throughout)
- sign=1, magnitude=0x05, start 1 cycle -> done pulse 9 cycles after start edge; result=0xFB, overflow=0; busy high for 9 cycles.
- sign=0, magnitude=0x7F -> result=0x7F, overflow=0. Then sign=1, magnitude=0x80 -> result=0x80, overflow=0.
- sign=0, magnitude=0x80 -> result=0x7F, overflow=1. sign=1, magnitude=0xC3 -> result=0x80, overflow=1.
- sign=1, magnitude=0x00 -> result=0x00, overflow=0. sign=1, magnitude=0x40 -> result=0xC0.
- Conversion of 0x03 negative in progress; start pulsed with magnitude=0x11 at SHIFT cycle 3 -> ignored; result=0xFD; exactly one done pulse.
- rst=1 at SHIFT cycle 4 -> next cycle busy=0, done=0, result=0; no done pulse. A fresh start with sign=1, magnitude=0x01 then gives 0xFF.
